// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and helpers for the nibble-serial adder sequencer.
// Holds the FSM state encoding, the slice width and the overflow rule.
package nibble_serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIBBLE_W = 4;

    // Two's-complement overflow: same-sign operands, result sign differs.
    function automatic logic ovf_calc(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_four_bit_adder.sv
// Combinational 4-bit ripple adder slice reused once per nibble step.
// Carry-in and carry-out let consecutive steps chain through a register.
module four_bit_adder
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
    assign sum   = total[NIBBLE_W-1:0];
    assign cout  = total[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract sequenced over one 4-bit slice, LS nibble first.
// Valid/ready on both sides; result is held in DONE until consumed.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int SW  = (NIB > 1) ? $clog2(NIB) : 1;

    state_e state, state_nx;

    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic                carry;
    logic [SW-1:0]       step;
    logic [WIDTH-1:0]    a_sh;
    logic [WIDTH-1:0]    b_sh;
    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic                c_nib;
    logic                accept;
    logic                last;

    assign a_sh   = a_q >> {step, 2'b00};
    assign b_sh   = b_q >> {step, 2'b00};
    assign a_nib  = a_sh[NIBBLE_W-1:0];
    assign b_nib  = b_sh[NIBBLE_W-1:0];
    assign accept = in_valid && in_ready;
    assign last   = (step == SW'(NIB - 1));

    four_bit_adder u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .sum  (s_nib),
        .cout (c_nib)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            step  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= op_sub ? ~b : b;
            carry <= op_sub | cin;
            step  <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < NIB; i++) begin
                if (step == SW'(i)) begin
                    sum[i*NIBBLE_W +: NIBBLE_W] <= s_nib;
                end
            end
            carry <= c_nib;
            if (last) begin
                step <= '0;
                cout <= c_nib;
                ovf  <= ovf_calc(a_q[WIDTH-1], b_q[WIDTH-1],
                                 s_nib[NIBBLE_W-1]);
            end else begin
                step <= step + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl at WIDTH=16.
// Vector table for arithmetic, plus hand-written backpressure/reset cases.
module tb_nibble_serial_adder_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int checks;
    int failures;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] esum;
        logic        ecout;
        logic        eovf;
    } vec_t;

    vec_t vecs[10];

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v, input int idx);
        int lat;
        int bc;
        @(negedge clk);
        chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        op_sub   = v.sub;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        bc  = busy ? 1 : 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bc++;
        end
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'd4);
        chk($sformatf("v%0d_sum", idx), 32'(sum), 32'(v.esum));
        chk($sformatf("v%0d_cout", idx), 32'(cout), 32'(v.ecout));
        chk($sformatf("v%0d_ovf", idx), 32'(ovf), 32'(v.eovf));
        if (out_ready) begin
            @(posedge clk);
            #1;
            if (busy) bc++;
            chk($sformatf("v%0d_busy_cycles", idx), 32'(bc), 32'd5);
            chk($sformatf("v%0d_idle_ready", idx), 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        vec_t v;
        int   seen;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op_sub    = 1'b0;
        out_ready = 1'b1;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[6] = '{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[9] = '{16'h1234, 16'h0001, 1'b1, 1'b0, 16'h1236, 1'b0, 1'b0};

        #22;
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'h0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i], i);
        end

        // Backpressure: result must hold while new requests are refused.
        out_ready = 1'b0;
        v = '{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0};
        do_op(v, 10);
        @(negedge clk);
        a        = 16'h0F0F;
        b        = 16'h00F1;
        cin      = 1'b0;
        op_sub   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_sum", i), 32'(sum), 32'h3333);
            chk($sformatf("bp%0d_cout", i), 32'(cout), 32'd0);
            chk($sformatf("bp%0d_ovf", i), 32'(ovf), 32'd0);
            chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
            chk($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_new_busy", 32'(busy), 32'd1);
        seen = 0;
        while (!out_valid && seen < 20) begin
            @(posedge clk);
            #1;
            seen++;
        end
        chk("bp_new_latency", 32'(seen), 32'd4);
        chk("bp_new_sum", 32'(sum), 32'h1000);
        chk("bp_new_cout", 32'(cout), 32'd0);
        chk("bp_new_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;

        // Reset two RUN edges into an operation.
        @(negedge clk);
        a        = 16'hFFFF;
        b        = 16'h0001;
        cin      = 1'b0;
        op_sub   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_sum", 32'(sum), 32'h0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("mid_rst_no_valid", 32'(seen), 32'd0);
        #3;
        rst_n = 1'b1;
        do_op(vecs[5], 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
